// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the byte-to-word converter.
//   MODE_8 / MODE_16 / MODE_32 : MODE encodings for 1, 2 and 4 byte words
//   mode_to_bytes()            : MODE -> word size in bytes, clamped to max_bytes
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int MODE_8  = 0;
  localparam int MODE_16 = 1;
  localparam int MODE_32 = 2;

  // Word size is 2^mode bytes. Modes beyond log2(max_bytes) saturate at max_bytes.
  // The loop has a fixed bound so the function stays synthesizable.
  function automatic int mode_to_bytes(input int mode, input int max_bytes);
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (i < mode && n < max_bytes) n = n * 2;
    end
    return n;
  endfunction

endpackage

// File: rtl/conv_out_reg.sv
// -----------------------------------------------------------------------------
// conv_out_reg
// Output holding stage for the byte-to-word converter.
// A load always wins over a consume on the same edge, so a new word replaces
// the one being drained and o_valid stays high. While o_valid is high and
// i_ready is low the stored word is held stable.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   i_load              capture i_data/i_bytes and raise o_valid
//   i_data, i_bytes     word and its valid byte count
//   i_ready             downstream consumes the word on this edge
//   o_data, o_bytes     registered word and byte count
//   o_valid             word available
// -----------------------------------------------------------------------------
module conv_out_reg #(
  parameter int W  = 32,
  parameter int BW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic [BW-1:0] i_bytes,
  input  logic          i_ready,
  output logic [W-1:0]  o_data,
  output logic [BW-1:0] o_bytes,
  output logic          o_valid
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_data  <= '0;
      o_bytes <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_bytes <= i_bytes;
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_8_to_n.sv
// -----------------------------------------------------------------------------
// conv_8_to_n
// Gathers a stream of bytes into words of 1, 2, 4 ... MAX_BYTES bytes, with the
// word size chosen per word from MODE. Valid/ready handshake on both sides.
// Optional feature macro: CONV_FLUSH_EN (adds the flush port, which emits a
// partial word; without it out_bytes always equals the latched word size).
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   ENB                            byte acceptance enable (drain continues)
//   MODE                           word size 2^MODE bytes, clamped
//   in_data, in_valid, in_ready    byte input handshake
//   out_data, out_bytes            word (byte 0 in [7:0]) and valid byte count
//   out_valid, out_ready           word output handshake
//   flush                          emit partial word (CONV_FLUSH_EN only)
// -----------------------------------------------------------------------------
module conv_8_to_n
  import conv_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int MODE_W    = $clog2($clog2(MAX_BYTES) + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENB,
  input  logic [MODE_W-1:0]          MODE,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [8*MAX_BYTES-1:0]     out_data,
  output logic [$clog2(MAX_BYTES):0] out_bytes,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef CONV_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int BW = $clog2(MAX_BYTES) + 1;

  logic [BW-1:0]              r_cnt;
  logic [BW-1:0]              r_nl;
  logic [8*(MAX_BYTES-1)-1:0] r_acc;

  logic [BW-1:0]              w_n_mode;
  logic [BW-1:0]              w_nl_eff;
  logic [BW-1:0]              w_load_bytes;
  logic [8*MAX_BYTES-1:0]     w_word;
  logic                       w_last;
  logic                       w_out_free;
  logic                       w_accept;
  logic                       w_complete;
  logic                       w_flush_load;
  logic                       w_load;

  assign w_n_mode = BW'(mode_to_bytes(int'(MODE), MAX_BYTES));

  // The word size is only taken from MODE at the start of a word.
  assign w_nl_eff   = (r_cnt == '0) ? w_n_mode : r_nl;
  assign w_last     = (r_cnt == w_nl_eff - BW'(1));
  assign w_out_free = !out_valid || out_ready;

  // Only the completing byte needs room in the output register.
  assign in_ready   = ENB && !RST && (!w_last || w_out_free);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && w_last;

`ifdef CONV_FLUSH_EN
  // A completing byte already produces a full word, so flush is moot then.
  assign w_flush_load = flush && (r_cnt != '0) && w_out_free && !w_complete;
`else
  assign w_flush_load = 1'b0;
`endif

  assign w_load       = w_complete || w_flush_load;
  assign w_load_bytes = w_complete ? w_nl_eff : (r_cnt + BW'(w_accept));

  // Merged word: stored lanes below cnt, the byte being accepted at lane cnt,
  // everything above zero. Stale accumulator lanes are masked out here rather
  // than cleared.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < MAX_BYTES - 1; k++) begin
      if (BW'(k) < r_cnt) w_word[8*k +: 8] = r_acc[8*k +: 8];
    end
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (w_accept && BW'(k) == r_cnt) w_word[8*k +: 8] = in_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_nl  <= BW'(1);
      r_acc <= '0;
    end else begin
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + BW'(1);
      end
      if (w_accept && r_cnt == '0) begin
        r_nl <= w_n_mode;
      end
      if (w_accept && !w_last) begin
        for (int k = 0; k < MAX_BYTES - 1; k++) begin
          if (BW'(k) == r_cnt) r_acc[8*k +: 8] <= in_data;
        end
      end
    end
  end

  conv_out_reg #(
    .W  (8 * MAX_BYTES),
    .BW (BW)
  ) u_out_reg (
    .CLK     (CLK),
    .RST     (RST),
    .i_load  (w_load),
    .i_data  (w_word),
    .i_bytes (w_load_bytes),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_bytes (out_bytes),
    .o_valid (out_valid)
  );

endmodule

// File: tb/tb_conv_8_to_n.sv
// -----------------------------------------------------------------------------
// tb_conv_8_to_n
// Directed and randomized stimulus for conv_8_to_n (MAX_BYTES=4), checked
// against a queue-based reference model of the byte/word handshake rules.
// Flush steps are only meaningful when built with CONV_FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_conv_8_to_n;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENB = 1'b0;
  logic [1:0]  MODE = 2'd0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  pq[$];
  int          nl_m = 1;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  int          m_bytes = 0;
  logic        exp_rdy = 1'b0;
  logic        last_acc = 1'b0;

  always #5 CLK = ~CLK;

  conv_8_to_n #(.MAX_BYTES(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENB       (ENB),
    .MODE      (MODE),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CONV_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  function automatic int clamp_n(input int m);
    return (m > 2) ? 4 : (1 << m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    nl_m    = 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_bytes = 0;
  endtask

  task automatic load_word(input int nb);
    m_data = '0;
    for (int i = 0; i < nb; i++) m_data = m_data | (32'(pq[i]) << (8 * i));
    m_bytes = nb;
    m_valid = 1'b1;
    pq.delete();
  endtask

  // One clock cycle: drive at negedge, check just after, update model at posedge.
  task automatic step(input logic rst, input logic enb, input logic [1:0] mode,
                      input logic iv, input logic [7:0] d, input logic ordy,
                      input logic fl);
    int   neff;
    int   precnt;
    logic free;
    logic loaded;
    @(negedge CLK);
    RST = rst; ENB = enb; MODE = mode; in_valid = iv; in_data = d;
    out_ready = ordy; flush = fl;
    #1;
    if (rst) model_reset();
    neff    = (pq.size() == 0) ? clamp_n(int'(mode)) : nl_m;
    exp_rdy = !rst && enb && ((pq.size() != neff - 1) || !m_valid || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || rst) begin
      chk("out_data", out_data, m_data);
      chk("out_bytes", 32'(out_bytes), 32'(m_bytes));
    end
    @(posedge CLK);
    last_acc = iv && exp_rdy;
    if (!rst) begin
      precnt = pq.size();
      free   = !m_valid || ordy;
      loaded = 1'b0;
      if (m_valid && ordy) m_valid = 1'b0;
      if (last_acc) begin
        if (pq.size() == 0) nl_m = clamp_n(int'(mode));
        pq.push_back(d);
        if (pq.size() == nl_m) begin
          load_word(nl_m);
          loaded = 1'b1;
        end
      end
`ifdef CONV_FLUSH_EN
      if (fl && precnt > 0 && free && !loaded) load_word(pq.size());
`endif
    end
  endtask

  // Offer a byte until it is accepted, bounded.
  task automatic send(input logic [1:0] mode, input logic [7:0] d, input logic ordy);
    int k;
    k = 0;
    do begin
      step(1'b0, 1'b1, mode, 1'b1, d, ordy, 1'b0);
      k++;
    end while (!last_acc && k < 20);
    chk("send_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b1, MODE, 1'b0, 8'h00, ordy, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b1, 2'd2, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd2, 1'b1, 8'h55, 1'b1, 1'b0);
    #1;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // 32-bit word
    send(2'd2, 8'h0F, 1'b1);
    send(2'd2, 8'hF0, 1'b1);
    send(2'd2, 8'hAA, 1'b1);
    send(2'd2, 8'h50, 1'b1);
    #1;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'h50AAF00F);
    chk("t1_bytes", 32'(out_bytes), 32'd4);
    idle(1'b1);
    #1;
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // 16-bit then back-to-back 8-bit words
    send(2'd1, 8'h70, 1'b1);
    send(2'd1, 8'h10, 1'b1);
    #1;
    chk("t2_data16", out_data, 32'h00001070);
    chk("t2_bytes16", 32'(out_bytes), 32'd2);
    send(2'd0, 8'hD0, 1'b1);
    #1;
    chk("t2_d0", out_data, 32'h000000D0);
    send(2'd0, 8'hF0, 1'b1);
    #1;
    chk("t2_f0", out_data, 32'h000000F0);
    send(2'd0, 8'hAE, 1'b1);
    #1;
    chk("t2_ae", out_data, 32'h000000AE);
    chk("t2_bytes8", 32'(out_bytes), 32'd1);
    idle(1'b1);

    // Backpressure: second word stalls on its completing byte
    for (int b = 1; b <= 7; b++) send(2'd2, 8'(b), 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b1, 8'h08, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b1, 8'h08, 1'b0, 1'b0);
    #1;
    chk("t3_held", out_data, 32'h04030201);
    chk("t3_stall", 32'(in_ready), 32'd0);
    send(2'd2, 8'h08, 1'b1);
    #1;
    chk("t3_next", out_data, 32'h08070605);
    chk("t3_valid", 32'(out_valid), 32'd1);
    idle(1'b1);

    // MODE change mid-word is ignored until the next word
    send(2'd2, 8'h11, 1'b1);
    send(2'd2, 8'h22, 1'b1);
    send(2'd0, 8'h33, 1'b1);
    send(2'd0, 8'h44, 1'b1);
    #1;
    chk("t4_word", out_data, 32'h44332211);
    chk("t4_bytes", 32'(out_bytes), 32'd4);
    send(2'd0, 8'h55, 1'b1);
    #1;
    chk("t4_single", out_data, 32'h00000055);
    chk("t4_bytes1", 32'(out_bytes), 32'd1);
    idle(1'b1);

`ifdef CONV_FLUSH_EN
    // Partial-word flush, then a flush with nothing accumulated
    send(2'd2, 8'h11, 1'b1);
    send(2'd2, 8'h22, 1'b1);
    send(2'd2, 8'h33, 1'b1);
    step(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    chk("t5_data", out_data, 32'h00332211);
    chk("t5_bytes", 32'(out_bytes), 32'd3);
    step(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    chk("t5_empty_flush", 32'(out_valid), 32'd0);
    idle(1'b1);
`endif

    // Reset in the middle of a word
    send(2'd2, 8'hB1, 1'b1);
    send(2'd2, 8'hB2, 1'b1);
    step(1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0);
    send(2'd2, 8'hA1, 1'b1);
    send(2'd2, 8'hA2, 1'b1);
    send(2'd2, 8'hA3, 1'b1);
    send(2'd2, 8'hA4, 1'b1);
    #1;
    chk("t6_data", out_data, 32'hA4A3A2A1);
    chk("t6_bytes", 32'(out_bytes), 32'd4);
    idle(1'b1);

    // Randomized traffic against the model
    begin
      logic [1:0] rmode;
      rmode = 2'd2;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 9) == 0) rmode = 2'($urandom_range(0, 3));
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 7) != 0),
             rmode,
             ($urandom_range(0, 3) != 0),
             8'($urandom),
             ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
